// File: rtl/rom_arbiter.sv
// ---------------------------------------------------------------------------
// rom_arbiter
//   Shares one single-port, synchronous-read ROM between two read requesters.
//   Port A is the core instruction fetch. Port B is the data-load path or the
//   GPU/DMA reader. Each access goes IDLE -> ISSUE -> CAPTURE -> IDLE, which
//   fits the ROM's one-cycle registered read. A tie between A and B goes to
//   the port that was not granted last. A word index at or beyond LEN is
//   flagged as out of range.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   a_req / b_req         : read request, held high until the matching gnt
//   a_addr / b_addr       : byte address, sampled in the grant cycle
//   a_gnt / b_gnt         : one-cycle pulse, request accepted
//   a_rvalid / b_rvalid   : one-cycle pulse, rdata/err valid
//   a_rdata / b_rdata     : read data, held until that port's next rvalid
//   a_err / b_err         : out-of-range flag, valid with rvalid
//   rom_enable            : high in the cycle the ROM samples rom_address
//   rom_address           : byte address to the ROM (the ROM uses [31:2])
//   rom_data              : ROM read data, valid the cycle after rom_enable
// ---------------------------------------------------------------------------
module rom_arbiter #(
  parameter int unsigned LEN = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        rom_enable,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state_q,       state_d;
  logic        last_b_q,      last_b_d;    // 1: B was granted most recently
  logic        winner_b_q,    winner_b_d;  // port owning the current access
  logic        oor_q,         oor_d;
  logic        a_gnt_q,       a_gnt_d;
  logic        b_gnt_q,       b_gnt_d;
  logic        a_rvalid_q,    a_rvalid_d;
  logic        b_rvalid_q,    b_rvalid_d;
  logic [31:0] a_rdata_q,     a_rdata_d;
  logic [31:0] b_rdata_q,     b_rdata_d;
  logic        a_err_q,       a_err_d;
  logic        b_err_q,       b_err_d;
  logic        rom_enable_q,  rom_enable_d;
  logic [31:0] rom_address_q, rom_address_d;

  // Arbitration helpers, only meaningful in IDLE.
  logic        pick_b;
  logic [31:0] win_addr;

  // B wins when it is the only requester, or on a tie when A went last.
  assign pick_b   = b_req && (!a_req || !last_b_q);
  assign win_addr = pick_b ? b_addr : a_addr;

  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a signal unassigned would infer a latch.
    state_d       = state_q;
    last_b_d      = last_b_q;
    winner_b_d    = winner_b_q;
    oor_d         = oor_q;
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    a_rvalid_d    = 1'b0;
    b_rvalid_d    = 1'b0;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;
    a_err_d       = a_err_q;
    b_err_d       = b_err_q;
    rom_enable_d  = 1'b0;
    rom_address_d = rom_address_q;

    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          rom_address_d = win_addr;
          winner_b_d    = pick_b;
          last_b_d      = pick_b;
          // Word index compare; addr[1:0] plays no part, so misalignment is legal.
          oor_d         = ({2'b00, win_addr[31:2]} >= LEN);
          a_gnt_d       = !pick_b;
          b_gnt_d       = pick_b;
          rom_enable_d  = 1'b1;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        // The ROM registers rom_address at the edge that leaves this state.
        state_d = CAPTURE;
      end

      CAPTURE: begin
        // rom_data is valid now. Only the owning port's outputs change.
        if (winner_b_q) begin
          b_rdata_d  = oor_q ? 32'h0 : rom_data;
          b_err_d    = oor_q;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = oor_q ? 32'h0 : rom_data;
          a_err_d    = oor_q;
          a_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // last_b_q resets to 1 so A wins the first tie.
      state_q       <= IDLE;
      last_b_q      <= 1'b1;
      winner_b_q    <= 1'b0;
      oor_q         <= 1'b0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      a_rdata_q     <= 32'h0;
      b_rdata_q     <= 32'h0;
      a_err_q       <= 1'b0;
      b_err_q       <= 1'b0;
      rom_enable_q  <= 1'b0;
      rom_address_q <= 32'h0;
    end else begin
      // NOTE: state registers use non-blocking assignment. All flops then
      // update together from the values they held before the edge.
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      winner_b_q    <= winner_b_d;
      oor_q         <= oor_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      a_err_q       <= a_err_d;
      b_err_q       <= b_err_d;
      rom_enable_q  <= rom_enable_d;
      rom_address_q <= rom_address_d;
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign a_err       = a_err_q;
  assign b_err       = b_err_q;
  assign rom_enable  = rom_enable_q;
  assign rom_address = rom_address_q;

endmodule
